// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding an LSB-first serialiser.
// Frames are sent back-to-back while the FIFO holds data.
`timescale 1ns/1ps
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          input_clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          Tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  logic          w_push;
  logic          w_pop;
  logic          w_baud_done;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count_next;

  assign w_push      = wr_en && !r_full;
  assign w_baud_done = (r_baud == BW'(CLKS_PER_BIT - 1));
  // A pop only happens on the edge that enters START, from IDLE or at the end of STOP.
  assign w_pop       = !r_empty &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Storage has no reset: after reset the pointers make old contents unreachable.
  always_ff @(posedge input_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge input_clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count    <= w_count_next;
      r_full     <= (w_count_next == CW'(FIFO_DEPTH));
      r_empty    <= (w_count_next == '0);
      r_overflow <= wr_en && r_full;
    end
  end

  always_ff @(posedge input_clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign full       = r_full;
  assign empty      = r_empty;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign busy       = r_busy;
  assign Tx         = r_tx;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Transmit-direction UART endpoint: accepts bytes from fabric logic through a write handshake, buffers them in an internal FIFO, and serialises them as 8N1 frames on Tx, LSB first.
- Sits beside the existing receive path so that status and capture data can be streamed back to the host without the producer waiting on baud timing.
- Back-to-back frames are sent with no idle gap while the FIFO holds data.

Parameters:
- CLKS_PER_BIT, 868, input_clk cycles per UART bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 16, byte entries in the buffer; must be a power of 2 and >= 2.

Ports:
- input_clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe; a byte is accepted on an edge where wr_en=1 and full=0.
- wr_data  in  8  byte to transmit; sampled with wr_en.
- full  out  1  FIFO holds FIFO_DEPTH entries (registered).
- empty  out  1  FIFO holds 0 entries (registered).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries (registered).
- overflow  out  1  one-cycle pulse when wr_en=1 arrives while full=1.
- busy  out  1  high whenever the serialiser is not in IDLE.
- Tx  out  1  serial line; idles high.

Behaviour:
- Reset, applied at any time including mid-frame: at the next edge Tx=1, busy=0, full=0, empty=1, fifo_count=0, overflow=0. Pointers are cleared, FIFO contents are discarded, the FSM goes to IDLE, and the bit and baud counters are cleared. No partial frame is resumed.
- FIFO storage:
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - full, empty and fifo_count are derived from a registered count.
- Write accepted: when wr_en && !full, the data goes to the slot at wr_ptr and wr_ptr increments.
- Write while full: the byte is dropped, FIFO state is unchanged, and overflow=1 for that cycle only. This applies even if a pop happens on the same edge, because full is evaluated before the edge.
- Pop: occurs only when the FSM leaves IDLE or STOP into START. The head byte is loaded into a shift register and rd_ptr increments.
- Simultaneous accepted write and pop: fifo_count is unchanged.
- FSM states and transitions (each bit period is exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1):
  - IDLE: Tx=1. If !empty, pop and go to START; Tx=0 is registered on the same edge.
  - START: Tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: Tx=shift_reg[0]. At the end of each bit period, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: Tx=1 for one bit period. At the end of the period, if !empty, pop and go directly to START; otherwise go to IDLE.
- Latency: for a write accepted at edge k into an empty, idle block, fifo_count=1 after edge k and Tx falls at edge k+1.
- Frame timing: a frame lasts exactly 10*CLKS_PER_BIT cycles. Consecutive frames abut, so the next start bit begins immediately after the stop bit.
- Tx is driven from a flop (no combinational path to the pin). busy is asserted from the edge that enters START until the edge that enters IDLE.
- Byte order is FIFO order. Nothing is reordered or duplicated.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then write 0xA5 at edge k -> Tx=0 from edge k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then Tx=1 for 4 cycles. busy stays high for 40 cycles, after which the block is in IDLE with empty=1.
- Write 0x01, 0x02, 0x03 on consecutive cycles -> fifo_count peaks at 2 (the first byte is popped immediately). Three contiguous frames span 120 cycles with no idle gap, and the decoded order is 0x01, 0x02, 0x03.
- Write 6 bytes 0x10..0x15 on consecutive cycles -> the first byte is popped, four are buffered and full=1, the sixth write produces one overflow pulse, and exactly 0x10..0x14 are transmitted.
- Keep the FIFO full while continuously writing on the exact edge of each STOP->START pop -> a write is accepted only on cycles where full=0 before the edge, and fifo_count never exceeds 4 or goes below 0.
- Assert reset for 1 cycle during bit 3 of a frame with 2 bytes queued -> the next edge shows Tx=1, busy=0 and empty=1, and no further Tx activity occurs until a new write.
- Write 0xFF and 0x00 after pointer wrap-around (more than 8 total writes) -> frames decode correctly and empty=1 at the end, with no stale data transmitted.
